// File: rtl/priority_arbiter_if.sv
// Request/grant bundle for the 4-way priority arbiter.
// The master side drives requests; the slave side is the arbiter itself.
interface priority_arbiter_if;
  logic [3:0] req;
  logic       rr_mode;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;

  modport master (
    output req, rr_mode,
    input  gnt, gnt_id, busy, timeout
  );

  modport slave (
    input  req, rr_mode,
    output gnt, gnt_id, busy, timeout
  );
endinterface

// File: rtl/priority_arbiter.sv
// Four-requester arbiter with fixed or round-robin priority, a non-preemptive grant,
// a bounded hold time and a one-cycle gap between consecutive grants.
module priority_arbiter #(
  parameter int MAX_HOLD = 15
) (
  input logic          clk,
  input logic          rst,
  priority_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  localparam logic [7:0] hold_max = 8'(MAX_HOLD);

  state_t     state, state_n;
  logic [3:0] gnt_q, gnt_n;
  logic [1:0] id_q, id_n;
  logic [1:0] last_q, last_n;
  logic       busy_q, busy_n;
  logic       timeout_q, timeout_n;
  logic [7:0] hold_q, hold_n;

  logic [3:0] eligible;
  logic [1:0] start;
  logic [1:0] idx;
  logic [1:0] pick;
  logic       found;

  // Descending search from the start index; fixed mode always starts at 3. A high
  // timeout register means we are in the gap right after a forced release, so the
  // requester that just timed out sits out this one arbitration.
  always_comb begin
    eligible = bus.req & ~(timeout_q ? (4'b0001 << last_q) : 4'b0000);
    start    = bus.rr_mode ? last_q - 2'd1 : 2'd3;
    found    = 1'b0;
    pick     = 2'd0;
    idx      = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = start - 2'(k);
      if (!found && eligible[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_n   = state;
    gnt_n     = gnt_q;
    id_n      = id_q;
    last_n    = last_q;
    busy_n    = busy_q;
    timeout_n = 1'b0;
    hold_n    = hold_q;

    case (state)
      IDLE, GAP: begin
        if (found) begin
          state_n = GRANT;
          gnt_n   = 4'b0001 << pick;
          id_n    = pick;
          busy_n  = 1'b1;
          hold_n  = 8'd1;
        end else begin
          state_n = IDLE;
          gnt_n   = 4'b0000;
          busy_n  = 1'b0;
          hold_n  = 8'd0;
        end
      end

      GRANT: begin
        // A dropped request wins over an expiring hold count, so no pulse then.
        if (!bus.req[id_q] || hold_q == hold_max) begin
          state_n   = GAP;
          gnt_n     = 4'b0000;
          busy_n    = 1'b0;
          hold_n    = 8'd0;
          last_n    = id_q;
          timeout_n = bus.req[id_q];
        end else begin
          hold_n = hold_q + 8'd1;
        end
      end

      default: begin
        state_n = IDLE;
        gnt_n   = 4'b0000;
        busy_n  = 1'b0;
        hold_n  = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt_q     <= 4'b0000;
      id_q      <= 2'd0;
      last_q    <= 2'd0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      hold_q    <= 8'd0;
    end else begin
      state     <= state_n;
      gnt_q     <= gnt_n;
      id_q      <= id_n;
      last_q    <= last_n;
      busy_q    <= busy_n;
      timeout_q <= timeout_n;
      hold_q    <= hold_n;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_id  = id_q;
  assign bus.busy    = busy_q;
  assign bus.timeout = timeout_q;

endmodule
